// File: rtl/tt_slot_pkg.sv
// ---------------------------------------------------------------------------
// tt_slot_pkg
// Shared types and bit positions for the project-slot multiplexer.
//   state_t      : slot controller state (IDLE / HOLD / ACTIVE)
//   *_BIT, *_LSB : field positions inside the per-slot input word
//                  {uio_in[7:0], ui_in[7:0], rst_n, clk} and output word
//                  {uio_oe[7:0], uio_out[7:0], uo_out[7:0]}
// ---------------------------------------------------------------------------
package tt_slot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Input word field positions
    localparam int CLK_BIT  = 0;
    localparam int RSTN_BIT = 1;
    localparam int UI_LSB   = 2;
    localparam int UIO_LSB  = 10;

    // Output word field positions
    localparam int UO_LSB      = 0;
    localparam int UIO_OUT_LSB = 8;
    localparam int UIO_OE_LSB  = 16;

    // Width of every byte-wide pad field
    localparam int FIELD_W = 8;

endpackage

// File: rtl/tt_slot_route.sv
// ---------------------------------------------------------------------------
// tt_slot_route
// Purely combinational routing between the pad-side words and the slots.
// Ports:
//   cur_addr  in  4               selected slot (always < NUM_PROJ)
//   state     in  state_t         controller state
//   rstn_gate in  1               1 lets the pad rst_n through to the slot
//   iw_in     in  IW_W            pad-side input word
//   proj_ow   in  NUM_PROJ*OW_W   flat per-slot output words
//   proj_iw   out NUM_PROJ*IW_W   flat per-slot input words
//   proj_ena  out NUM_PROJ        one-hot (or zero) slot enable
//   sel_ow    out OW_W            selected slot's output word, 0 unless ACTIVE
// ---------------------------------------------------------------------------
module tt_slot_route
    import tt_slot_pkg::*;
#(
    parameter int NUM_PROJ = 8,
    parameter int IW_W     = 18,
    parameter int OW_W     = 24
) (
    input  logic [3:0]               cur_addr,
    input  state_t                   state,
    input  logic                     rstn_gate,
    input  logic [IW_W-1:0]          iw_in,
    input  logic [NUM_PROJ*OW_W-1:0] proj_ow,
    output logic [NUM_PROJ*IW_W-1:0] proj_iw,
    output logic [NUM_PROJ-1:0]      proj_ena,
    output logic [OW_W-1:0]          sel_ow
);

    logic [IW_W-1:0] slot_word_s;
    logic [OW_W-1:0] picked_ow_s;
    logic            slot_on_s;
    logic            ow_on_s;

    assign slot_on_s = (state != IDLE);
    assign ow_on_s   = (state == ACTIVE);

    // Build the word seen by the selected slot: rst_n gated, other fields pass
    always_comb begin
        slot_word_s                       = {IW_W{1'b0}};
        slot_word_s[CLK_BIT]              = iw_in[CLK_BIT];
        slot_word_s[RSTN_BIT]             = iw_in[RSTN_BIT] & rstn_gate;
        slot_word_s[UI_LSB +: FIELD_W]    = iw_in[UI_LSB +: FIELD_W];
        slot_word_s[UIO_LSB +: FIELD_W]   = iw_in[UIO_LSB +: FIELD_W];
    end

    // Fan the word and enable out to the selected slot only; others see zero
    always_comb begin
        proj_iw  = {(NUM_PROJ*IW_W){1'b0}};
        proj_ena = {NUM_PROJ{1'b0}};
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (slot_on_s && (cur_addr == 4'(k))) begin
                proj_iw[k*IW_W +: IW_W] = slot_word_s;
                proj_ena[k]             = 1'b1;
            end else begin
                proj_iw[k*IW_W +: IW_W] = {IW_W{1'b0}};
                proj_ena[k]             = 1'b0;
            end
        end
    end

    // Fan in the selected slot's output word while ACTIVE
    always_comb begin
        picked_ow_s = {OW_W{1'b0}};
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (ow_on_s && (cur_addr == 4'(k))) begin
                picked_ow_s = proj_ow[k*OW_W +: OW_W];
            end else begin
                picked_ow_s = picked_ow_s;
            end
        end
    end

    // Reassemble the pad output fields from the picked word
    always_comb begin
        sel_ow                             = {OW_W{1'b0}};
        sel_ow[UO_LSB +: FIELD_W]          = picked_ow_s[UO_LSB +: FIELD_W];
        sel_ow[UIO_OUT_LSB +: FIELD_W]     = picked_ow_s[UIO_OUT_LSB +: FIELD_W];
        sel_ow[UIO_OE_LSB +: FIELD_W]      = picked_ow_s[UIO_OE_LSB +: FIELD_W];
    end

endmodule

// File: rtl/tt_proj_slot_mux.sv
// ---------------------------------------------------------------------------
// tt_proj_slot_mux
// Multiplexes one pad-side word bundle across NUM_PROJ project slots. A load
// strobe selects a slot; the slot is enabled at once and its rst_n held low
// for RST_HOLD cycles before it becomes ACTIVE and drives the pads.
// Ports:
//   clk       in  1               block clock
//   rst       in  1               synchronous active-high reset
//   sel_load  in  1               one-cycle strobe: load sel_addr
//   sel_addr  in  4               requested slot index
//   iw_in     in  IW_W            pad-side input word
//   ow_out    out OW_W            pad-side output word
//   proj_iw   out NUM_PROJ*IW_W   flat per-slot input words
//   proj_ena  out NUM_PROJ        per-slot enable
//   proj_ow   in  NUM_PROJ*OW_W   flat per-slot output words
//   active    out 1               1 while ACTIVE
//   cur_addr  out 4               currently selected slot
//   sel_err   out 1               one-cycle pulse after an out-of-range load
// ---------------------------------------------------------------------------
module tt_proj_slot_mux
    import tt_slot_pkg::*;
#(
    parameter int NUM_PROJ = 8,
    parameter int IW_W     = 18,
    parameter int OW_W     = 24,
    parameter int RST_HOLD = 4,
    parameter int OUT_REG  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_load,
    input  logic [3:0]               sel_addr,
    input  logic [IW_W-1:0]          iw_in,
    output logic [OW_W-1:0]          ow_out,
    output logic [NUM_PROJ*IW_W-1:0] proj_iw,
    output logic [NUM_PROJ-1:0]      proj_ena,
    input  logic [NUM_PROJ*OW_W-1:0] proj_ow,
    output logic                     active,
    output logic [3:0]               cur_addr,
    output logic                     sel_err
);

    localparam int             CNT_W    = $clog2(RST_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // One extra bit so NUM_PROJ=16 is representable in the range compare
    localparam logic [4:0]     NUM_LIM  = 5'(NUM_PROJ);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       addr_r, addr_s;
    logic             err_r, err_s;
    logic             addr_ok_s;
    logic             rstn_gate_s;
    logic [OW_W-1:0]  sel_ow_s;

    // All four address bits take part, so 4'hF is rejected for NUM_PROJ<16
    assign addr_ok_s   = ({1'b0, sel_addr} < NUM_LIM);
    assign rstn_gate_s = (state_r == ACTIVE);

    // Next-state logic: any load restarts HOLD or aborts to IDLE
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        err_s   = 1'b0;
        if (sel_load) begin
            if (addr_ok_s) begin
                state_s = HOLD;
                cnt_s   = CNT_LOAD;
                addr_s  = sel_addr;
            end else begin
                state_s = IDLE;
                err_s   = 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                HOLD: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_s = ACTIVE;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ACTIVE: begin
                    state_s = ACTIVE;
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter, address and error-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            addr_r  <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            err_r   <= err_s;
        end
    end

    tt_slot_route #(
        .NUM_PROJ (NUM_PROJ),
        .IW_W     (IW_W),
        .OW_W     (OW_W)
    ) u_route (
        .cur_addr  (addr_r),
        .state     (state_r),
        .rstn_gate (rstn_gate_s),
        .iw_in     (iw_in),
        .proj_ow   (proj_ow),
        .proj_iw   (proj_iw),
        .proj_ena  (proj_ena),
        .sel_ow    (sel_ow_s)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [OW_W-1:0] ow_r;

            // Pad output register: one cycle behind the selected slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    ow_r <= {OW_W{1'b0}};
                end else begin
                    ow_r <= sel_ow_s;
                end
            end

            assign ow_out = ow_r;
        end else begin : g_out_comb
            assign ow_out = sel_ow_s;
        end
    endgenerate

    assign active   = (state_r == ACTIVE);
    assign cur_addr = addr_r;
    assign sel_err  = err_r;

endmodule

// File: tb/tb_tt_proj_slot_mux.sv
module tb_tt_proj_slot_mux;

    localparam int NP = 8;
    localparam int IW = 18;
    localparam int OW = 24;

    localparam logic [17:0] W_IDLE = 18'h3FFFF;
    localparam logic [17:0] W_ACT  = 18'h2AAA7;
    localparam logic [17:0] W_HOLD = 18'h2AAA5;
    localparam logic [23:0] OW3    = 24'hC3A55A;
    localparam logic [23:0] OWX    = 24'hFFFFFF;

    typedef struct {
        string          nm;
        logic [NP-1:0]  ena;
        logic [NP*IW-1:0] iw;
        logic           act;
        logic [OW-1:0]  ow;
        logic           err;
        logic [3:0]     addr;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             sel_load;
    logic [3:0]       sel_addr;
    logic [IW-1:0]    iw_in;
    logic [OW-1:0]    ow_out;
    logic [NP*IW-1:0] proj_iw;
    logic [NP-1:0]    proj_ena;
    logic [NP*OW-1:0] proj_ow;
    logic             active;
    logic [3:0]       cur_addr;
    logic             sel_err;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    tt_proj_slot_mux #(
        .NUM_PROJ (NP),
        .IW_W     (IW),
        .OW_W     (OW),
        .RST_HOLD (4),
        .OUT_REG  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_load (sel_load),
        .sel_addr (sel_addr),
        .iw_in    (iw_in),
        .ow_out   (ow_out),
        .proj_iw  (proj_iw),
        .proj_ena (proj_ena),
        .proj_ow  (proj_ow),
        .active   (active),
        .cur_addr (cur_addr),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string nm, input logic [7:0] ena, input int slot,
                                input logic [17:0] w, input logic act, input logic [23:0] ow,
                                input logic err, input logic [3:0] addr);
        exp_t e;
        e.nm   = nm;
        e.ena  = ena;
        e.iw   = '0;
        if (slot >= 0) e.iw[slot*IW +: IW] = w;
        e.act  = act;
        e.ow   = ow;
        e.err  = err;
        e.addr = addr;
        return e;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [NP*IW-1:0] got,
                       input logic [NP*IW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, got, want);
        end
    endtask

    // Expectation for the cycle that follows this clock edge
    task automatic tick(input exp_t e);
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "proj_ena", {{(NP*IW-NP){1'b0}}, proj_ena}, {{(NP*IW-NP){1'b0}}, e.ena});
            chk(e.nm, "proj_iw",  proj_iw, e.iw);
            chk(e.nm, "active",   {{(NP*IW-1){1'b0}}, active},   {{(NP*IW-1){1'b0}}, e.act});
            chk(e.nm, "ow_out",   {{(NP*IW-OW){1'b0}}, ow_out},  {{(NP*IW-OW){1'b0}}, e.ow});
            chk(e.nm, "sel_err",  {{(NP*IW-1){1'b0}}, sel_err},  {{(NP*IW-1){1'b0}}, e.err});
            chk(e.nm, "cur_addr", {{(NP*IW-4){1'b0}}, cur_addr}, {{(NP*IW-4){1'b0}}, e.addr});
        end
    end

    initial begin
        rst      = 1'b1;
        sel_load = 1'b0;
        sel_addr = 4'd0;
        iw_in    = W_IDLE;
        for (int k = 0; k < NP; k++) proj_ow[k*OW +: OW] = (k == 3) ? OW3 : OWX;

        // Reset state
        tick(mk("rst0", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd0));
        tick(mk("rst1", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd0));
        rst = 1'b0;

        // Idle with all-ones pad input: nothing reaches any slot
        repeat (10) tick(mk("idle", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd0));

        // Select slot 3: four HOLD cycles, then ACTIVE, ow_out one later
        iw_in    = W_ACT;
        sel_load = 1'b1;
        sel_addr = 4'd3;
        tick(mk("hold3_first", 8'h08, 3, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd3));
        sel_load = 1'b0;
        repeat (3) tick(mk("hold3", 8'h08, 3, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd3));
        tick(mk("act3_first", 8'h08, 3, W_ACT, 1'b1, 24'h0, 1'b0, 4'd3));
        repeat (3) tick(mk("act3", 8'h08, 3, W_ACT, 1'b1, OW3, 1'b0, 4'd3));

        // Switch to slot 5: enables swap on one edge; ow_out drains then zero
        sel_load = 1'b1;
        sel_addr = 4'd5;
        tick(mk("sw5_first", 8'h20, 5, W_HOLD, 1'b0, OW3, 1'b0, 4'd5));
        sel_load = 1'b0;
        repeat (3) tick(mk("hold5", 8'h20, 5, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd5));
        tick(mk("act5_first", 8'h20, 5, W_ACT, 1'b1, 24'h0, 1'b0, 4'd5));
        tick(mk("act5", 8'h20, 5, W_ACT, 1'b1, OWX, 1'b0, 4'd5));

        // Out-of-range load 9: IDLE, one-cycle sel_err, address kept
        sel_load = 1'b1;
        sel_addr = 4'd9;
        tick(mk("err9", 8'h00, -1, 18'h0, 1'b0, OWX, 1'b1, 4'd5));
        sel_load = 1'b0;
        tick(mk("err9_clr", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd5));

        // Boundary: address 8 is the first invalid one
        sel_load = 1'b1;
        sel_addr = 4'd8;
        tick(mk("err8", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b1, 4'd5));
        sel_load = 1'b0;
        tick(mk("err8_clr", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd5));

        // Boundary: address 7 valid; reload of same address restarts HOLD
        sel_load = 1'b1;
        sel_addr = 4'd7;
        tick(mk("hold7_first", 8'h80, 7, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd7));
        sel_load = 1'b0;
        tick(mk("hold7", 8'h80, 7, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd7));
        sel_load = 1'b1;
        tick(mk("hold7_reload", 8'h80, 7, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd7));
        sel_load = 1'b0;
        repeat (3) tick(mk("hold7_restart", 8'h80, 7, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd7));
        tick(mk("act7_first", 8'h80, 7, W_ACT, 1'b1, 24'h0, 1'b0, 4'd7));
        tick(mk("act7", 8'h80, 7, W_ACT, 1'b1, OWX, 1'b0, 4'd7));

        // Reset at HOLD counter=2 together with a load: reset wins, no error
        sel_load = 1'b1;
        sel_addr = 4'd2;
        tick(mk("hold2_first", 8'h04, 2, W_HOLD, 1'b0, OWX, 1'b0, 4'd2));
        sel_load = 1'b0;
        tick(mk("hold2_cnt2", 8'h04, 2, W_HOLD, 1'b0, 24'h0, 1'b0, 4'd2));
        rst      = 1'b1;
        sel_load = 1'b1;
        sel_addr = 4'd6;
        tick(mk("rst_mid", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd0));
        rst      = 1'b0;
        sel_load = 1'b0;
        tick(mk("rst_after", 8'h00, -1, 18'h0, 1'b0, 24'h0, 1'b0, 4'd0));

        // Drain the scoreboard within a bounded number of cycles
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
